// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   ADDR_WIDTH_DEF / INST_WIDTH_DEF : default address and instruction widths
//   fetch_state_t                   : 2-bit FSM encoding (FETCH, MISS, REFILL)
//   PC_INC                          : sequential PC step in bytes
package inst_fetcher_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int INST_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        MISS   = 2'd1,
        REFILL = 2'd2
    } fetch_state_t;

    localparam int PC_INC = 4;

endpackage

// File: rtl/inst_fetcher.sv
// Instruction-fetch front end.
// Holds the PC and looks it up in the Icache every cycle. On a hit it delivers
// one instruction per cycle to the decode queue. On a miss it requests the word
// from the memory controller and writes the returned word into the Icache.
// A flush from commit redirects the PC and abandons any outstanding miss.
// Ports:
//   clk_in, rst_in         : clock, synchronous active-high reset
//   rdy_in                 : global ready, low freezes all state and outputs
//   ic_to_if_hit/_inst     : combinational Icache lookup result for the PC
//   if_to_ic_inst_addr     : lookup / fill address (always the current PC)
//   if_to_ic_inst/_valid   : Icache refill data and one-cycle write strobe
//   if_to_mc_req/_addr     : memory read request (level) and address
//   mc_to_if_done/_inst    : memory read completion pulse and data
//   dq_full                : decode queue back-pressure
//   if_to_dq_valid/_inst/_pc : delivered instruction and its PC
//   flush, flush_pc        : redirect request and target
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    INST_WIDTH = INST_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  ic_to_if_hit,
    input  logic [INST_WIDTH-1:0] ic_to_if_hit_inst,
    output logic [ADDR_WIDTH-1:0] if_to_ic_inst_addr,
    output logic [INST_WIDTH-1:0] if_to_ic_inst,
    output logic                  if_to_ic_inst_valid,
    output logic                  if_to_mc_req,
    output logic [ADDR_WIDTH-1:0] if_to_mc_addr,
    input  logic                  mc_to_if_done,
    input  logic [INST_WIDTH-1:0] mc_to_if_inst,
    input  logic                  dq_full,
    output logic                  if_to_dq_valid,
    output logic [INST_WIDTH-1:0] if_to_dq_inst,
    output logic [ADDR_WIDTH-1:0] if_to_dq_pc,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc
);

    fetch_state_t          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [INST_WIDTH-1:0] ic_inst_reg, ic_inst_next;
    logic                  ic_valid_reg, ic_valid_next;
    logic                  mc_req_reg, mc_req_next;
    logic [ADDR_WIDTH-1:0] mc_addr_reg, mc_addr_next;
    logic                  dq_valid_reg, dq_valid_next;
    logic [INST_WIDTH-1:0] dq_inst_reg, dq_inst_next;
    logic [ADDR_WIDTH-1:0] dq_pc_reg, dq_pc_next;

    always_comb begin
        // Hold everything by default; this is exactly the rdy_in=0 behaviour,
        // including keeping a pending strobe visible.
        state_next    = state_reg;
        pc_next       = pc_reg;
        ic_inst_next  = ic_inst_reg;
        ic_valid_next = ic_valid_reg;
        mc_req_next   = mc_req_reg;
        mc_addr_next  = mc_addr_reg;
        dq_valid_next = dq_valid_reg;
        dq_inst_next  = dq_inst_reg;
        dq_pc_next    = dq_pc_reg;

        if (rdy_in) begin
            // Strobes are single-cycle pulses in every ready cycle.
            ic_valid_next = 1'b0;
            dq_valid_next = 1'b0;

            if (flush) begin
                // Dropping req aborts the memory read; a done arriving in the
                // same cycle is discarded because no refill strobe is raised.
                pc_next     = flush_pc;
                state_next  = FETCH;
                mc_req_next = 1'b0;
            end else begin
                case (state_reg)
                    FETCH: begin
                        if (ic_to_if_hit) begin
                            if (!dq_full) begin
                                dq_valid_next = 1'b1;
                                dq_inst_next  = ic_to_if_hit_inst;
                                dq_pc_next    = pc_reg;
                                // Natural modulo-2^ADDR_WIDTH wrap.
                                pc_next       = pc_reg + ADDR_WIDTH'(PC_INC);
                            end
                        end else begin
                            // Misses start regardless of decode-queue space.
                            mc_req_next  = 1'b1;
                            mc_addr_next = pc_reg;
                            state_next   = MISS;
                        end
                    end
                    MISS: begin
                        if (mc_to_if_done) begin
                            mc_req_next   = 1'b0;
                            ic_inst_next  = mc_to_if_inst;
                            ic_valid_next = 1'b1;
                            state_next    = REFILL;
                        end
                    end
                    REFILL: begin
                        // Icache is written at the end of this cycle; the
                        // following FETCH lookup then hits.
                        state_next = FETCH;
                    end
                    default: begin
                        state_next = FETCH;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            ic_inst_reg  <= '0;
            ic_valid_reg <= 1'b0;
            mc_req_reg   <= 1'b0;
            mc_addr_reg  <= '0;
            dq_valid_reg <= 1'b0;
            dq_inst_reg  <= '0;
            dq_pc_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ic_inst_reg  <= ic_inst_next;
            ic_valid_reg <= ic_valid_next;
            mc_req_reg   <= mc_req_next;
            mc_addr_reg  <= mc_addr_next;
            dq_valid_reg <= dq_valid_next;
            dq_inst_reg  <= dq_inst_next;
            dq_pc_reg    <= dq_pc_next;
        end
    end

    assign if_to_ic_inst_addr  = pc_reg;
    assign if_to_ic_inst       = ic_inst_reg;
    assign if_to_ic_inst_valid = ic_valid_reg;
    assign if_to_mc_req        = mc_req_reg;
    assign if_to_mc_addr       = mc_addr_reg;
    assign if_to_dq_valid      = dq_valid_reg;
    assign if_to_dq_inst       = dq_inst_reg;
    assign if_to_dq_pc         = dq_pc_reg;

endmodule
